// File: rtl/clk_pkg.sv
// Shared definitions for the hours/minutes/seconds counter: mode encoding,
// field limits and a two-digit BCD increment helper.
package clk_pkg;

    // Operating mode; encoding 2'd3 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    // Highest legal value of each field before it wraps to 00.
    localparam int SEC_MIN_MAX = 59;
    localparam int HR_MAX      = 23;

    // Two BCD digits of one time field.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Result of one increment: the new field value and whether it wrapped.
    typedef struct packed {
        logic  wrap;
        bcd2_t val;
    } bcd_step_t;

    // Advance a BCD field by one, wrapping to 00 after max_val. Anything at
    // or above the limit also folds back to 00, so a field never leaves range.
    function automatic bcd_step_t bcd_inc(input bcd2_t cur, input int max_val);
        bcd_step_t r;
        r.wrap = 1'b0;
        if ((int'(cur.tens) * 10 + int'(cur.ones)) >= max_val) begin
            r.val  = '0;
            r.wrap = 1'b1;
        end else if (cur.ones == 4'd9) begin
            r.val.tens = cur.tens + 4'd1;
            r.val.ones = 4'd0;
        end else begin
            r.val.tens = cur.tens;
            r.val.ones = cur.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchroniser chain plus rising-edge detector for one asynchronous input.
// Produces a single-clk pulse per low-to-high transition of d.
module edge_sync #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw input through the synchroniser and keep one history bit.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state here resets to 0 so an input already high when
        // reset lifts is seen as a fresh edge, and a half-synchronised edge
        // caught by reset is discarded rather than emitted afterwards.
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the value
            // its neighbour held before this edge, which is what makes a chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/hms_counter.sv
// BCD 24-hour clock with RUN / SET_HR / SET_MIN modes. The tick input and
// both buttons are synchronised and edge-detected; time fields form a
// seconds -> minutes -> hours carry chain.
module hms_counter
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_o,
    output logic [3:0] sec_t,
    output logic [3:0] min_o,
    output logic [3:0] min_t,
    output logic [3:0] hr_o,
    output logic [3:0] hr_t,
    output logic [1:0] mode,
    output logic       day_pulse
);

    logic tick_p;
    logic mode_p;
    logic inc_p;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .clk   (clk),
        .rst   (rst),
        .d     (tick_in),
        .pulse (tick_p)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
        .clk   (clk),
        .rst   (rst),
        .d     (btn_mode),
        .pulse (mode_p)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
        .clk   (clk),
        .rst   (rst),
        .d     (btn_inc),
        .pulse (inc_p)
    );

    mode_t     state_q;
    mode_t     state_nxt;
    bcd2_t     sec_q;
    bcd2_t     min_q;
    bcd2_t     hr_q;
    logic      day_pulse_q;
    bcd_step_t sec_step;
    bcd_step_t min_step;
    bcd_step_t hr_step;

    assign sec_step = bcd_inc(sec_q, SEC_MIN_MAX);
    assign min_step = bcd_inc(min_q, SEC_MIN_MAX);
    assign hr_step  = bcd_inc(hr_q,  HR_MAX);

    // Mode register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next mode: the mode button steps RUN -> SET_HR -> SET_MIN -> RUN.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // driven, so no latch is inferred when no branch matches.
        state_nxt = state_q;
        case (state_q)
            RUN:     if (mode_p) state_nxt = SET_HR;
            SET_HR:  if (mode_p) state_nxt = SET_MIN;
            SET_MIN: if (mode_p) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Time fields: tick-driven carry chain in RUN, direct field edit in SET
    // modes. Updates use the current mode, so a simultaneous mode pulse is
    // applied after the tick or increment of this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            day_pulse_q <= 1'b0;
        end else begin
            day_pulse_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (tick_p) begin
                        sec_q <= sec_step.val;
                        if (sec_step.wrap) begin
                            min_q <= min_step.val;
                            if (min_step.wrap) begin
                                hr_q        <= hr_step.val;
                                day_pulse_q <= hr_step.wrap;
                            end
                        end
                    end
                end
                SET_HR: begin
                    if (inc_p) hr_q <= hr_step.val;
                end
                SET_MIN: begin
                    if (inc_p)  min_q <= min_step.val;
                    if (mode_p) sec_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sec_o     = sec_q.ones;
    assign sec_t     = sec_q.tens;
    assign min_o     = min_q.ones;
    assign min_t     = min_q.tens;
    assign hr_o      = hr_q.ones;
    assign hr_t      = hr_q.tens;
    assign mode      = state_q;
    assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_hms_counter.sv
// Self-checking bench for hms_counter: a table of single-pulse vectors,
// directed multi-cycle sequences, and random pulses against a time-of-day model.
module tb_hms_counter;

    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec_o, sec_t, min_o, min_t, hr_o, hr_t;
    logic [1:0] mode;
    logic       day_pulse;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers for hours, minutes, seconds and mode.
    int m_h, m_mn, m_s, m_mode;
    bit m_dp;

    hms_counter #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_o     (sec_o),
        .sec_t     (sec_t),
        .min_o     (min_o),
        .min_t     (min_t),
        .hr_o      (hr_o),
        .hr_t      (hr_t),
        .mode      (mode),
        .day_pulse (day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    typedef struct {
        bit tk;
        bit md;
        bit ic;
        int h;
        int mn;
        int s;
        int mode;
    } vec_t;

    vec_t vecs [14];

    // Packed view {0, mode, day_pulse, hh, mm, ss} of the DUT outputs.
    function automatic logic [27:0] dut_vec();
        return {1'b0, mode, day_pulse, hr_t, hr_o, min_t, min_o, sec_t, sec_o};
    endfunction

    function automatic logic [27:0] exp_vec(int h, int mn, int s, int md, bit dp);
        logic [7:0] hb, mb, sb;
        hb = {4'(h / 10),  4'(h % 10)};
        mb = {4'(mn / 10), 4'(mn % 10)};
        sb = {4'(s / 10),  4'(s % 10)};
        return {1'b0, 2'(md), dp, hb, mb, sb};
    endfunction

    task automatic check(string name, logic [27:0] got, logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {mode,dp}/hh/mm/ss=%h required=%h", name, got, exp);
        end
    endtask

    task automatic check_model(string name);
        check(name, dut_vec(), exp_vec(m_h, m_mn, m_s, m_mode, m_dp));
    endtask

    task automatic model_reset();
        m_h = 0; m_mn = 0; m_s = 0; m_mode = 0; m_dp = 1'b0;
    endtask

    // Apply one set of simultaneous input pulses to the model.
    task automatic model_step(bit tk, bit md, bit ic);
        int tod;
        m_dp = 1'b0;
        case (m_mode)
            0: begin
                if (tk) begin
                    tod  = m_h * 3600 + m_mn * 60 + m_s;
                    m_dp = (tod == 86399);
                    tod  = (tod + 1) % 86400;
                    m_h  = tod / 3600;
                    m_mn = (tod / 60) % 60;
                    m_s  = tod % 60;
                end
                if (md) m_mode = 1;
            end
            1: begin
                if (ic) m_h = (m_h + 1) % 24;
                if (md) m_mode = 2;
            end
            default: begin
                if (ic) m_mn = (m_mn + 1) % 60;
                if (md) begin
                    m_mode = 0;
                    m_s    = 0;
                end
            end
        endcase
    endtask

    // Raise the chosen inputs for one clk (first sampled at edge N), then
    // check: unchanged after N+S-1, updated after N+S, day_pulse gone after N+S+1.
    // Called and returns just after a falling edge.
    task automatic apply(bit tk, bit md, bit ic, string name);
        tick_in  = tk;
        btn_mode = md;
        btn_inc  = ic;
        @(posedge clk);
        @(negedge clk);
        tick_in  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (S - 1) @(negedge clk);
        m_dp = 1'b0;
        check_model({name, " early"});
        @(negedge clk);
        model_step(tk, md, ic);
        check_model(name);
        @(negedge clk);
        m_dp = 1'b0;
        check_model({name, " settle"});
    endtask

    // Assert reset between edges, confirm it acts without a clock, release on a falling edge.
    task automatic do_reset(string name);
        #2 rst = 1'b0;
        model_reset();
        #1 check_model({name, " immediate"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        tick_in  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        model_reset();

        #3 check_model("reset state");
        repeat (2) @(negedge clk);
        check_model("reset held over clocks");
        rst = 1'b1;

        // Table of single-pulse vectors from 00:00:00 RUN.
        vecs[0]  = '{1'b1, 1'b0, 1'b0,  0, 0, 1, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,  0, 0, 2, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1,  0, 0, 2, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0,  0, 0, 3, 1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  0, 0, 3, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1,  1, 0, 3, 1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1,  2, 0, 3, 2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0,  2, 0, 3, 2};
        vecs[8]  = '{1'b0, 1'b0, 1'b1,  2, 1, 3, 2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1,  2, 2, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0,  2, 2, 1, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0,  2, 2, 1, 1};
        vecs[12] = '{1'b0, 1'b1, 1'b0,  2, 2, 1, 2};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  2, 2, 0, 0};
        for (int k = 0; k < 14; k++) begin
            apply(vecs[k].tk, vecs[k].md, vecs[k].ic, $sformatf("vec%0d", k));
            check($sformatf("vec%0d table", k), dut_vec(),
                  exp_vec(vecs[k].h, vecs[k].mn, vecs[k].s, vecs[k].mode, 1'b0));
        end

        // Ten ticks from reset.
        do_reset("reset before ticks");
        for (int k = 0; k < 10; k++) apply(1'b1, 1'b0, 1'b0, $sformatf("tick%0d", k));
        check("ten ticks", dut_vec(), exp_vec(0, 0, 10, 0, 1'b0));

        // Hours wrap through 24, minutes through 60, seconds cleared on return.
        apply(1'b0, 1'b1, 1'b0, "enter set_hr");
        for (int k = 0; k < 25; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("hr inc%0d", k));
        check("25 hour incs", dut_vec(), exp_vec(1, 0, 10, 1, 1'b0));
        apply(1'b0, 1'b1, 1'b0, "enter set_min");
        for (int k = 0; k < 61; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("min inc%0d", k));
        check("61 minute incs", dut_vec(), exp_vec(1, 1, 10, 2, 1'b0));
        apply(1'b0, 1'b1, 1'b0, "back to run");
        check("run with seconds cleared", dut_vec(), exp_vec(1, 1, 0, 0, 1'b0));

        // Preload 23:59:58 and roll over midnight.
        apply(1'b0, 1'b1, 1'b0, "preload set_hr");
        for (int k = 0; k < 22; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("preload hr%0d", k));
        apply(1'b0, 1'b1, 1'b0, "preload set_min");
        for (int k = 0; k < 58; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("preload min%0d", k));
        apply(1'b0, 1'b1, 1'b0, "preload run");
        for (int k = 0; k < 58; k++) apply(1'b1, 1'b0, 1'b0, $sformatf("preload sec%0d", k));
        check("preload 23:59:58", dut_vec(), exp_vec(23, 59, 58, 0, 1'b0));
        apply(1'b1, 1'b0, 1'b0, "to 23:59:59");
        check("at 23:59:59", dut_vec(), exp_vec(23, 59, 59, 0, 1'b0));
        apply(1'b1, 1'b0, 1'b0, "midnight rollover");
        check("after rollover", dut_vec(), exp_vec(0, 0, 0, 0, 1'b0));

        // Ticks frozen in SET_HR; a held button counts once.
        apply(1'b0, 1'b1, 1'b0, "freeze set_hr");
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 1'b0, $sformatf("frozen tick%0d", k));
        check("ticks ignored in set_hr", dut_vec(), exp_vec(0, 0, 0, 1, 1'b0));
        btn_inc = 1'b1;
        repeat (100) @(negedge clk);
        btn_inc = 1'b0;
        repeat (S + 2) @(negedge clk);
        m_h = (m_h + 1) % 24;
        check_model("held inc counts once");
        apply(1'b0, 1'b1, 1'b0, "leave set_hr");
        apply(1'b0, 1'b1, 1'b0, "leave set_min");

        // Mode and tick on the same cycle.
        do_reset("reset before mode+tick");
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 1'b0, $sformatf("pre tick%0d", k));
        apply(1'b1, 1'b1, 1'b0, "mode+tick");
        check("mode+tick result", dut_vec(), exp_vec(0, 0, 6, 1, 1'b0));

        // Reset while a tick is still in the synchroniser: nothing leaks out.
        tick_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick_in = 1'b0;
        do_reset("reset with tick in flight");
        repeat (S + 4) @(negedge clk);
        check_model("no residual tick");

        // Random pulses against the model.
        for (int k = 0; k < 200; k++) begin
            bit tk, md, ic;
            tk = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 3) == 0);
            ic = 1'($urandom_range(0, 1));
            apply(tk, md, ic, $sformatf("rand%0d", k));
        end

        // Reach 12:34:56 in SET_MIN, reset there, release with mode held high.
        do_reset("reset before 12:34:56");
        apply(1'b0, 1'b1, 1'b0, "b set_hr");
        for (int k = 0; k < 12; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("b hr%0d", k));
        apply(1'b0, 1'b1, 1'b0, "b set_min");
        for (int k = 0; k < 34; k++) apply(1'b0, 1'b0, 1'b1, $sformatf("b min%0d", k));
        apply(1'b0, 1'b1, 1'b0, "b run");
        for (int k = 0; k < 56; k++) apply(1'b1, 1'b0, 1'b0, $sformatf("b sec%0d", k));
        apply(1'b0, 1'b1, 1'b0, "b set_hr again");
        apply(1'b0, 1'b1, 1'b0, "b set_min again");
        check("12:34:56 in set_min", dut_vec(), exp_vec(12, 34, 56, 2, 1'b0));
        #3 rst = 1'b0;
        model_reset();
        #1 check_model("reset in set_min immediate");
        btn_mode = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        repeat (S - 1) @(negedge clk);
        check_model("held mode before latency");
        @(negedge clk);
        m_mode = 1;
        check_model("held mode one transition");
        repeat (20) @(negedge clk);
        check_model("held mode still set_hr");
        btn_mode = 1'b0;
        repeat (S + 2) @(negedge clk);
        check_model("mode released set_hr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
